// File: rtl/td4_prog_loader.sv
// td4_prog_loader: streams a program image into the 16x8 TD4 instruction store
// and holds the core in reset until the image is complete. Optional checksum: TD4_LOADER_CHECKSUM_EN.
`default_nettype none

module td4_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    FAIL  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wptr, wptr_nx;
  logic              done_nx;
  logic              xfer;
  logic              last;
  logic [DATA_W-1:0] mem [DEPTH];

  assign xfer = in_valid & in_ready;
  assign last = (wptr == {ADDR_W{1'b1}});

`ifdef TD4_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] chk;

  assign chk = sum + in_data;

  always_ff @(posedge clock) begin
    if (reset || load_start) begin
      sum <= '0;
    end else if (state == LOAD && xfer) begin
      sum <= sum + in_data;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    wptr_nx  = wptr;
    done_nx  = 1'b0;
    if (load_start) begin
      // a restart always wins over a byte offered in the same cycle
      state_nx = LOAD;
      wptr_nx  = '0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            wptr_nx = wptr + 1'b1;
            if (last) begin
`ifdef TD4_LOADER_CHECKSUM_EN
              state_nx = CHECK;
`else
              state_nx = RUN;
              done_nx  = 1'b1;
`endif
            end
          end
        end
`ifdef TD4_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            if (chk == '0) begin
              state_nx = RUN;
              done_nx  = 1'b1;
            end else begin
              state_nx = FAIL;
            end
          end
        end
`endif
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wptr     <= '0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      cpu_run  <= 1'b0;
    end else begin
      state    <= state_nx;
      wptr     <= wptr_nx;
      done     <= done_nx;
      in_ready <= (state_nx == LOAD) || (state_nx == CHECK);
      cpu_run  <= (state_nx == RUN);
    end
  end

`ifdef TD4_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (state_nx == FAIL);
    end
  end
`else
  assign err = 1'b0;
`endif

  // memory is deliberately never cleared, so a reset mid-load leaves old words behind
  always_ff @(posedge clock) begin
    if (!reset && !load_start && state == LOAD && xfer) begin
      mem[wptr] <= in_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: tb/tb_td4_prog_loader.sv
// Randomized self-checking bench for td4_prog_loader against a phase/counter reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_td4_prog_loader;

`ifdef TD4_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_FAIL = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic       cpu_run;
  logic       done;
  logic       err;

  td4_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cpu_run(cpu_run), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: loader phase, bytes received so far, running sum
  int         phase = P_IDLE;
  int         count = 0;
  int         msum  = 0;
  bit         exp_done = 1'b0;
  logic [7:0] mmem  [16];
  bit         known [16];

  logic [7:0] image [16] = '{8'h3C, 8'h36, 8'h73, 8'h79, 8'h10, 8'h3C, 8'h40, 8'h0C,
                             8'h53, 8'h20, 8'h60, 8'hB5, 8'h90, 8'h0F, 8'hE2, 8'hBA};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    exp_done = 1'b0;
    if (reset) begin
      phase = P_IDLE; count = 0; msum = 0;
    end else if (load_start) begin
      phase = P_LOAD; count = 0; msum = 0;
    end else if (in_valid && phase == P_LOAD) begin
      mmem[count] = in_data;
      known[count] = 1'b1;
      msum = (msum + int'(in_data)) % 256;
      count = count + 1;
      if (count == 16) begin
        count = 0;
        if (CK) phase = P_CHECK;
        else begin phase = P_RUN; exp_done = 1'b1; end
      end
    end else if (in_valid && phase == P_CHECK) begin
      if ((msum + int'(in_data)) % 256 == 0) begin phase = P_RUN; exp_done = 1'b1; end
      else phase = P_FAIL;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_eq("in_ready", in_ready, (phase == P_LOAD || phase == P_CHECK));
    check_eq("cpu_run", cpu_run, (phase == P_RUN));
    check_eq("done", done, exp_done);
    check_eq("err", err, (phase == P_FAIL));
    rd_addr = 4'($urandom_range(0, 15));
    #0.5;
    if (known[rd_addr]) check_eq("rd_data_rand", rd_data, mmem[rd_addr]);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #0.2;
      if (known[i]) check_eq(tag, rd_data, mmem[i]);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // offer one byte; stalls idle cycles before it when asked
  task automatic send(input logic [7:0] b, input int stall);
    in_valid = 1'b0;
    for (int s = 0; s < stall; s++) tick();
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] good_ck(input int s);
    return 8'((256 - s) % 256);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) known[i] = 1'b0;

    // reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // directed image, valid held high
    start_load();
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = image[i];
      tick();
    end
    if (CK) begin
      in_data = good_ck(msum);
      tick();
    end
    in_valid = 1'b0;
    check_eq("run_after_image", cpu_run, 1'b1);
    rd_addr = 4'hB;
    #0.2;
    check_eq("word_B", rd_data, 8'hB5);
    check_mem("image_mem");
    tick();

    // bytes offered in RUN are ignored
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    check_mem("run_mem");

    // bad checksum bytes (only meaningful with checksum enabled)
    if (CK) begin
      start_load();
      for (int i = 0; i < 16; i++) send(image[i], 0);
      send(8'h00, 0);
      check_eq("bad_ck_err", err, 1'b1);
      tick();
      tick();
      start_load();
      check_eq("err_cleared", err, 1'b0);
      for (int i = 0; i < 16; i++) send(image[i], 0);
      send(8'h5F, 0);
      tick();
    end

    // in_valid toggling every other cycle
    start_load();
    for (int i = 0; i < 16; i++) send(8'($urandom), 1);
    if (CK) send(good_ck(msum), 1);
    tick();
    check_mem("toggle_mem");

    // restart after byte 7, then a full image of 0x11
    start_load();
    for (int i = 0; i < 7; i++) send(8'($urandom), 0);
    start_load();
    for (int i = 0; i < 16; i++) send(8'h11, 0);
    if (CK) send(good_ck(msum), 0);
    tick();
    check_mem("restart_mem");

    // reset after byte 5
    start_load();
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_mem("reset_mid_mem");

    // load_start colliding with a byte: byte is dropped
    start_load();
    send(8'h77, 0);
    in_data = 8'h99; in_valid = 1'b1; load_start = 1'b1;
    tick();
    load_start = 1'b0; in_valid = 1'b0;
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      load_start = ($urandom_range(0, 60) == 0);
      reset      = ($urandom_range(0, 400) == 0);
      // steer toward valid checksums half the time
      if (CK && phase == P_CHECK && $urandom_range(0, 1) == 1) in_data = good_ck(msum);
      tick();
    end
    reset = 1'b0; load_start = 1'b0; in_valid = 1'b0;
    tick();
    check_mem("final_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
